// File: rtl/mem_access_stage_if.sv
// Data-memory port bundle: request/response signals between the memory stage and data memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    // Pipeline stage side: issues requests, receives read data and ready.
    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    // Memory side: accepts requests, returns read data and ready.
    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: branch resolution, data-memory access with wait-state stall and timeout,
// load alignment/extension, and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_exe,
    input  logic [31:0] data2_exe,
    input  logic [31:0] pc_target_exe,
    input  logic [4:0]  rd_exe,
    input  logic [2:0]  funct3_exe,
    input  logic        RegWrite_exe,
    input  logic        MemRead_exe,
    input  logic        MemWrite_exe,
    input  logic        MemtoReg_exe,
    input  logic        branch_exe,
    input  logic        jump_exe,
    input  logic        jalr_exe,
    input  logic        Zero_exe,
    input  logic        carry_out_exe,
    input  logic        Negative_exe,
    input  logic        Overflow_exe,
    mem_access_stage_if.master dmem,
    output logic        StallM,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        RegWrite_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] result_wb,
    output logic        misalign_wb,
    output logic        bus_err_wb
);

    typedef enum logic {StIdle, StWait} state_e;

    // Wide enough to hold TIMEOUT_CYCLES; never zero width.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        reg_write_wb_q, reg_write_wb_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic [31:0] result_wb_q, result_wb_d;
    logic        misalign_wb_q, misalign_wb_d;
    logic        bus_err_wb_q, bus_err_wb_d;

    logic [1:0]  byte_off;
    logic        mem_access;
    logic        misaligned;
    logic        mem_op;
    logic        abort;
    logic        branch_cond;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted_rdata;
    logic [31:0] load_result;

    assign byte_off   = alu_result_exe[1:0];
    assign mem_access = MemRead_exe | MemWrite_exe;

    // Alignment check, byte enables and lane-replicated store data from access size.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = data2_exe;
        case (funct3_exe[1:0])
            2'b00: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{data2_exe[7:0]}};
            end
            2'b01: begin
                misaligned = byte_off[0];
                be         = 4'b0011 << byte_off;
                wdata      = {2{data2_exe[15:0]}};
            end
            default: begin
                misaligned = (byte_off != 2'b00);
            end
        endcase
        misaligned = misaligned & mem_access;
    end

    assign mem_op = mem_access & ~misaligned;

    // Timeout fires only while still waiting on the final allowed cycle; ready wins over abort.
    assign abort = (state_q == StWait) && mem_op && !dmem.dmem_ready &&
                   (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));

    assign StallM = mem_op & ~dmem.dmem_ready & ~abort;

    // Request is gated by reset so an in-flight access drops immediately on reset.
    assign dmem.dmem_req   = mem_op & rst;
    assign dmem.dmem_we    = MemWrite_exe;
    assign dmem.dmem_addr  = {alu_result_exe[31:2], 2'b00};
    assign dmem.dmem_be    = be;
    assign dmem.dmem_wdata = wdata;

    // Branch condition from the registered rs1-rs2 flags.
    always_comb begin
        branch_cond = 1'b0;
        case (funct3_exe)
            3'b000:  branch_cond = Zero_exe;
            3'b001:  branch_cond = ~Zero_exe;
            3'b100:  branch_cond = Negative_exe ^ Overflow_exe;
            3'b101:  branch_cond = ~(Negative_exe ^ Overflow_exe);
            3'b110:  branch_cond = ~carry_out_exe;
            3'b111:  branch_cond = carry_out_exe;
            default: branch_cond = 1'b0;
        endcase
    end

    assign PCSrcM    = jump_exe | jalr_exe | (branch_exe & branch_cond);
    assign PCTargetM = pc_target_exe;

    // Load data alignment and sign/zero extension.
    always_comb begin
        shifted_rdata = dmem.dmem_rdata >> {byte_off, 3'b000};
        case (funct3_exe)
            3'b000:  load_result = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b001:  load_result = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  load_result = {24'b0, shifted_rdata[7:0]};
            3'b101:  load_result = {16'b0, shifted_rdata[15:0]};
            default: load_result = shifted_rdata;
        endcase
    end

    // Wait-state FSM next state: count cycles spent waiting for ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mem_op && !dmem.dmem_ready) begin
                    state_d = StWait;
                    cnt_d   = CntW'(1);
                end
            end
            StWait: begin
                if (!mem_op || dmem.dmem_ready || abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Wait-state FSM registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB next state: bubble while stalled, otherwise capture the instruction's result.
    always_comb begin
        rd_wb_d        = rd_wb_q;
        result_wb_d    = result_wb_q;
        reg_write_wb_d = 1'b0;
        misalign_wb_d  = 1'b0;
        bus_err_wb_d   = 1'b0;
        if (!StallM) begin
            rd_wb_d        = rd_exe;
            result_wb_d    = MemtoReg_exe ? load_result : alu_result_exe;
            reg_write_wb_d = RegWrite_exe & ~misaligned & ~abort;
            misalign_wb_d  = misaligned;
            bus_err_wb_d   = abort;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_wb_q <= 1'b0;
            rd_wb_q        <= '0;
            result_wb_q    <= '0;
            misalign_wb_q  <= 1'b0;
            bus_err_wb_q   <= 1'b0;
        end else begin
            reg_write_wb_q <= reg_write_wb_d;
            rd_wb_q        <= rd_wb_d;
            result_wb_q    <= result_wb_d;
            misalign_wb_q  <= misalign_wb_d;
            bus_err_wb_q   <= bus_err_wb_d;
        end
    end

    assign RegWrite_wb = reg_write_wb_q;
    assign rd_wb       = rd_wb_q;
    assign result_wb   = result_wb_q;
    assign misalign_wb = misalign_wb_q;
    assign bus_err_wb  = bus_err_wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized loads/stores/branches against a
// byte-level reference model, plus wait-state, timeout and reset-during-wait scenarios.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_exe, data2_exe, pc_target_exe;
    logic [4:0]  rd_exe;
    logic [2:0]  funct3_exe;
    logic        RegWrite_exe, MemRead_exe, MemWrite_exe, MemtoReg_exe;
    logic        branch_exe, jump_exe, jalr_exe;
    logic        Zero_exe, carry_out_exe, Negative_exe, Overflow_exe;
    logic        StallM, PCSrcM;
    logic [31:0] PCTargetM;
    logic        RegWrite_wb, misalign_wb, bus_err_wb;
    logic [4:0]  rd_wb;
    logic [31:0] result_wb;

    int total = 0;
    int bad   = 0;

    mem_access_stage_if dif ();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_result_exe (alu_result_exe),
        .data2_exe      (data2_exe),
        .pc_target_exe  (pc_target_exe),
        .rd_exe         (rd_exe),
        .funct3_exe     (funct3_exe),
        .RegWrite_exe   (RegWrite_exe),
        .MemRead_exe    (MemRead_exe),
        .MemWrite_exe   (MemWrite_exe),
        .MemtoReg_exe   (MemtoReg_exe),
        .branch_exe     (branch_exe),
        .jump_exe       (jump_exe),
        .jalr_exe       (jalr_exe),
        .Zero_exe       (Zero_exe),
        .carry_out_exe  (carry_out_exe),
        .Negative_exe   (Negative_exe),
        .Overflow_exe   (Overflow_exe),
        .dmem           (dif),
        .StallM         (StallM),
        .PCSrcM         (PCSrcM),
        .PCTargetM      (PCTargetM),
        .RegWrite_wb    (RegWrite_wb),
        .rd_wb          (rd_wb),
        .result_wb      (result_wb),
        .misalign_wb    (misalign_wb),
        .bus_err_wb     (bus_err_wb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [7:0] t;
        t = ((8'd1 << nbytes(f3)) - 8'd1) << (addr % 4);
        return t[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int unsigned n;
        n = nbytes(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] w, mask;
        int unsigned n;
        n    = nbytes(f3);
        w    = rdata >> (8 * (addr % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        w    = w & mask;
        if (!f3[2] && n < 4 && w[8*n-1]) w = w | ~mask;
        return w;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic set_idle();
        alu_result_exe = '0; data2_exe = '0; pc_target_exe = '0; rd_exe = '0; funct3_exe = '0;
        RegWrite_exe = 0; MemRead_exe = 0; MemWrite_exe = 0; MemtoReg_exe = 0;
        branch_exe = 0; jump_exe = 0; jalr_exe = 0;
        Zero_exe = 0; carry_out_exe = 0; Negative_exe = 0; Overflow_exe = 0;
        dif.dmem_ready = 0; dif.dmem_rdata = '0;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [4:0] rd);
        set_idle();
        funct3_exe = f3; alu_result_exe = addr; rd_exe = rd;
        MemRead_exe = 1; RegWrite_exe = 1; MemtoReg_exe = 1;
    endtask

    task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] d);
        set_idle();
        funct3_exe = f3; alu_result_exe = addr; data2_exe = d; MemWrite_exe = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        rst = 0;
        drive_load(3'b010, 32'h100, 5'd3);
        #22;
        total++; if (dif.dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dif.dmem_req); end
        total++; if ({RegWrite_wb, rd_wb, result_wb, misalign_wb, bus_err_wb} !== '0) begin
            bad++; $display("FAIL reset_regs got=%b/%h/%h/%b/%b want=all zero",
                            RegWrite_wb, rd_wb, result_wb, misalign_wb, bus_err_wb);
        end
        set_idle();
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [4] = '{3'b010, 3'b000, 3'b100, 3'b001};
        logic [31:0] ads [4] = '{32'h100, 32'h103, 32'h103, 32'h102};
        logic [31:0] rds [4] = '{32'hDEADBEEF, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234};
        logic [31:0] exs [4] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        for (int i = 0; i < 4; i++) begin
            drive_load(f3s[i], ads[i], 5'd7);
            dif.dmem_ready = 1; dif.dmem_rdata = rds[i];
            @(negedge clk);
            total++; if (StallM !== 1'b0) begin bad++; $display("FAIL dir_ld_stall[%0d] got=%b want=0", i, StallM); end
            @(posedge clk); #1;
            total++; if (result_wb !== exs[i]) begin bad++; $display("FAIL dir_ld_data[%0d] got=%h want=%h", i, result_wb, exs[i]); end
            total++; if (RegWrite_wb !== 1'b1) begin bad++; $display("FAIL dir_ld_we[%0d] got=%b want=1", i, RegWrite_wb); end
        end
        drive_store(3'b001, 32'h102, 32'h1234ABCD);
        dif.dmem_ready = 1;
        @(negedge clk);
        total++; if (dif.dmem_be !== 4'b1100) begin bad++; $display("FAIL dir_sh_be got=%b want=1100", dif.dmem_be); end
        total++; if (dif.dmem_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL dir_sh_wdata got=%h want=abcdabcd", dif.dmem_wdata); end
        total++; if (dif.dmem_we !== 1'b1 || dif.dmem_req !== 1'b1) begin bad++; $display("FAIL dir_sh_we_req got=%b%b want=11", dif.dmem_we, dif.dmem_req); end
        @(posedge clk); #1;
        drive_load(3'b010, 32'h101, 5'd9);
        dif.dmem_ready = 1;
        @(negedge clk);
        total++; if (dif.dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL dir_mis_req got=%b%b want=00", dif.dmem_req, StallM); end
        @(posedge clk); #1;
        total++; if (misalign_wb !== 1'b1 || RegWrite_wb !== 1'b0) begin bad++; $display("FAIL dir_mis_wb got=%b%b want=10", misalign_wb, RegWrite_wb); end
    endtask

    task automatic test_random_loads();
        logic [2:0]  codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] addr, rdata;
        logic [4:0]  rd;
        bit          mis;
        for (int i = 0; i < 60; i++) begin
            f3 = codes[$urandom_range(0, 4)];
            addr = $urandom; rd = 5'($urandom); rdata = $urandom;
            mis = ref_mis(f3, addr);
            drive_load(f3, addr, rd);
            dif.dmem_ready = 1; dif.dmem_rdata = rdata;
            @(negedge clk);
            total++; if (dif.dmem_req !== !mis) begin bad++; $display("FAIL rl_req[%0d] got=%b want=%b", i, dif.dmem_req, !mis); end
            total++; if (dif.dmem_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL rl_addr[%0d] got=%h want=%h", i, dif.dmem_addr, {addr[31:2], 2'b00}); end
            if (!mis) begin
                total++; if (dif.dmem_be !== ref_be(f3, addr)) begin bad++; $display("FAIL rl_be[%0d] got=%b want=%b", i, dif.dmem_be, ref_be(f3, addr)); end
            end
            @(posedge clk); #1;
            total++; if (misalign_wb !== mis || RegWrite_wb !== !mis) begin bad++; $display("FAIL rl_flags[%0d] got=%b%b want=%b%b", i, misalign_wb, RegWrite_wb, mis, !mis); end
            total++; if (rd_wb !== rd) begin bad++; $display("FAIL rl_rd[%0d] got=%0d want=%0d", i, rd_wb, rd); end
            if (!mis) begin
                total++; if (result_wb !== ref_load(f3, addr, rdata)) begin bad++; $display("FAIL rl_data[%0d] f3=%0d a=%h got=%h want=%h", i, f3, addr, result_wb, ref_load(f3, addr, rdata)); end
            end
        end
    endtask

    task automatic test_random_stores();
        logic [2:0]  f3;
        logic [31:0] addr, d;
        bit          mis;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 2));
            addr = $urandom; d = $urandom;
            mis = ref_mis(f3, addr);
            drive_store(f3, addr, d);
            dif.dmem_ready = 1;
            @(negedge clk);
            total++; if (dif.dmem_req !== !mis || dif.dmem_we !== 1'b1) begin bad++; $display("FAIL rs_req[%0d] got=%b%b want=%b1", i, dif.dmem_req, dif.dmem_we, !mis); end
            if (!mis) begin
                total++; if (dif.dmem_be !== ref_be(f3, addr)) begin bad++; $display("FAIL rs_be[%0d] got=%b want=%b", i, dif.dmem_be, ref_be(f3, addr)); end
                total++; if (dif.dmem_wdata !== ref_wdata(f3, d)) begin bad++; $display("FAIL rs_wdata[%0d] got=%h want=%h", i, dif.dmem_wdata, ref_wdata(f3, d)); end
            end
            @(posedge clk); #1;
            total++; if (misalign_wb !== mis || RegWrite_wb !== 1'b0) begin bad++; $display("FAIL rs_wb[%0d] got=%b%b want=%b0", i, misalign_wb, RegWrite_wb, mis); end
            total++; if (result_wb !== addr) begin bad++; $display("FAIL rs_result[%0d] got=%h want=%h", i, result_wb, addr); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] a, b, tgt, diff;
        logic [32:0] s;
        logic [2:0]  f3;
        int unsigned mode;
        bit          exp;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
            f3 = 3'($urandom_range(0, 7)); tgt = $urandom; mode = $urandom_range(0, 3);
            set_idle();
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            diff = s[31:0];
            Zero_exe = (diff == 0); carry_out_exe = s[32]; Negative_exe = diff[31];
            Overflow_exe = (a[31] != b[31]) && (diff[31] != a[31]);
            funct3_exe = f3; pc_target_exe = tgt; alu_result_exe = a ^ b; RegWrite_exe = 1;
            branch_exe = (mode == 0); jump_exe = (mode == 1); jalr_exe = (mode == 2);
            exp = (mode == 1) || (mode == 2) || ((mode == 0) && ref_taken(f3, a, b));
            @(negedge clk);
            total++; if (PCSrcM !== exp) begin bad++; $display("FAIL br_pcsrc[%0d] f3=%0d mode=%0d got=%b want=%b", i, f3, mode, PCSrcM, exp); end
            total++; if (PCTargetM !== tgt) begin bad++; $display("FAIL br_target[%0d] got=%h want=%h", i, PCTargetM, tgt); end
            total++; if (dif.dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL br_noreq[%0d] got=%b%b want=00", i, dif.dmem_req, StallM); end
            @(posedge clk); #1;
            total++; if (result_wb !== (a ^ b) || RegWrite_wb !== 1'b1) begin bad++; $display("FAIL br_alu_wb[%0d] got=%h/%b want=%h/1", i, result_wb, RegWrite_wb, a ^ b); end
        end
        set_idle(); funct3_exe = 3'b110; branch_exe = 1; carry_out_exe = 0; pc_target_exe = 32'h0000_4000;
        @(negedge clk);
        total++; if (PCSrcM !== 1'b1 || PCTargetM !== 32'h0000_4000) begin bad++; $display("FAIL bltu_dir got=%b/%h want=1/00004000", PCSrcM, PCTargetM); end
        funct3_exe = 3'b111;
        #1;
        total++; if (PCSrcM !== 1'b0) begin bad++; $display("FAIL bgeu_dir got=%b want=0", PCSrcM); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [2:0]  codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] addr, rdata;
        int unsigned n;
        for (int i = 0; i < 12; i++) begin
            n = (i < 5) ? i : $urandom_range(0, TO);
            f3 = codes[$urandom_range(0, 4)];
            addr = $urandom & ~(nbytes(f3) - 1);
            rdata = $urandom;
            drive_load(f3, addr, 5'd12);
            for (int k = 0; k < int'(n); k++) begin
                @(negedge clk);
                total++; if (StallM !== 1'b1 || dif.dmem_req !== 1'b1) begin bad++; $display("FAIL ws_stall[%0d.%0d] got=%b%b want=11", i, k, StallM, dif.dmem_req); end
                @(posedge clk); #1;
                total++; if (RegWrite_wb !== 1'b0 || bus_err_wb !== 1'b0) begin bad++; $display("FAIL ws_bubble[%0d.%0d] got=%b%b want=00", i, k, RegWrite_wb, bus_err_wb); end
            end
            dif.dmem_ready = 1; dif.dmem_rdata = rdata;
            @(negedge clk);
            total++; if (StallM !== 1'b0) begin bad++; $display("FAIL ws_release[%0d] got=%b want=0", i, StallM); end
            @(posedge clk); #1;
            total++; if (result_wb !== ref_load(f3, addr, rdata) || RegWrite_wb !== 1'b1 || bus_err_wb !== 1'b0) begin
                bad++; $display("FAIL ws_data[%0d] n=%0d got=%h/%b/%b want=%h/1/0", i, n, result_wb, RegWrite_wb, bus_err_wb, ref_load(f3, addr, rdata));
            end
        end
    endtask

    task automatic test_timeout();
        drive_load(3'b010, 32'h200, 5'd5);
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            total++; if (StallM !== 1'b1) begin bad++; $display("FAIL to_stall[%0d] got=%b want=1", k, StallM); end
            @(posedge clk); #1;
            total++; if (bus_err_wb !== 1'b0) begin bad++; $display("FAIL to_early[%0d] got=%b want=0", k, bus_err_wb); end
        end
        @(negedge clk);
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL to_abort_stall got=%b want=0", StallM); end
        @(posedge clk); #1;
        total++; if (bus_err_wb !== 1'b1 || RegWrite_wb !== 1'b0 || misalign_wb !== 1'b0) begin
            bad++; $display("FAIL to_err got=%b%b%b want=100", bus_err_wb, RegWrite_wb, misalign_wb);
        end
        set_idle();
        @(posedge clk); #1;
        total++; if (bus_err_wb !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b want=0", bus_err_wb); end
    endtask

    task automatic test_reset_mid_wait();
        drive_load(3'b010, 32'h300, 5'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        total++; if (dif.dmem_req !== 1'b0) begin bad++; $display("FAIL rmw_req got=%b want=0", dif.dmem_req); end
        #1;
        rst = 1;
        // Counter must restart from idle: full TO stall cycles before the abort.
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            total++; if (StallM !== 1'b1) begin bad++; $display("FAIL rmw_stall[%0d] got=%b want=1", k, StallM); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL rmw_abort got=%b want=0", StallM); end
        @(posedge clk); #1;
        total++; if (bus_err_wb !== 1'b1) begin bad++; $display("FAIL rmw_err got=%b want=1", bus_err_wb); end
        set_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_loads();
        test_random_stores();
        test_branch();
        test_wait_states();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
